pw_bit_rx: RTL

- Pulse-width bit receiver: the downstream counterpart of pw_bit_cell. It consumes the txd waveform that pw_bit_cell produces.
- Measures the high time of each bit cell, slices it against a threshold and assembles bits MSB-first into bytes.
- Emits bytes on an AXI-Stream master. A low-idle timeout delimits frames and marks the final byte with tlast.

---
 rtl/pw_bit_rx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pw_bit_rx.sv
// Pulse-width bit receiver. Measures the high time of each bit cell on rxd,
// slices it against a threshold to get a bit, and packs bits MSB-first into
// words on an AXI-Stream master. A long low period ends the frame, and the
// final word of the frame is marked with tlast.
module pw_bit_rx #(
  parameter int COUNTER_WIDTH        = 8,
  parameter int DATA_AXIS_DATA_WIDTH = 8,
  parameter int CFG_AXIS_DATA_WIDTH  = 8
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             rxd,
  input  logic [CFG_AXIS_DATA_WIDTH-1:0]   threshold,
  input  logic [CFG_AXIS_DATA_WIDTH-1:0]   timeout,
  output logic [DATA_AXIS_DATA_WIDTH-1:0]  data_m_axis_tdata,
  output logic                             data_m_axis_tlast,
  output logic                             data_m_axis_tvalid,
  input  logic                             data_m_axis_tready,
  output logic                             overrun,
  output logic                             frame_err
);

  localparam int BitCntW = $clog2(DATA_AXIS_DATA_WIDTH + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_AXIS_DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    WAIT_LOW,
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t                          r_state;
  logic                            r_sync1;
  logic                            r_rxdS;
  logic [COUNTER_WIDTH-1:0]        r_highCnt;
  logic [COUNTER_WIDTH-1:0]        r_lowCnt;
  logic [DATA_AXIS_DATA_WIDTH-2:0] r_shreg;
  logic [BitCntW-1:0]              r_bitCnt;
  logic [DATA_AXIS_DATA_WIDTH-1:0] r_pendData;
  logic                            r_pendValid;
  logic [DATA_AXIS_DATA_WIDTH-1:0] r_tdata;
  logic                            r_tlast;
  logic                            r_tvalid;
  logic                            r_overrun;
  logic                            r_frameErr;

  logic [COUNTER_WIDTH-1:0]        w_thresholdExt;
  logic [COUNTER_WIDTH-1:0]        w_timeoutExt;
  logic                            w_timeoutOn;
  logic                            w_bit;
  logic [DATA_AXIS_DATA_WIDTH-1:0] w_word;
  logic                            w_fall;
  logic                            w_rise;
  logic                            w_wordDone;
  logic                            w_timeoutHit;
  logic                            w_push;
  logic [DATA_AXIS_DATA_WIDTH-1:0] w_pushData;
  logic                            w_pushLast;

  assign w_thresholdExt = COUNTER_WIDTH'(threshold);
  assign w_timeoutExt   = COUNTER_WIDTH'(timeout);
  assign w_timeoutOn    = (timeout != '0);

  // Two-flop synchroniser; left out of reset so a line held high through
  // reset is already visible as high when reset releases.
  always_ff @(posedge aclk) begin
    r_sync1 <= rxd;
    r_rxdS  <= r_sync1;
  end

  // Line events and the word that the push logic would hand to the output.
  always_comb begin
    w_bit        = (r_highCnt >= w_thresholdExt);
    w_word       = {r_shreg, w_bit};
    w_fall       = (r_state == HIGH) && !r_rxdS;
    w_rise       = (r_state == LOW) && r_rxdS;
    w_wordDone   = w_fall && (r_bitCnt == LastBit);
    w_timeoutHit = (r_state == LOW) && !r_rxdS && w_timeoutOn &&
                   (r_lowCnt == w_timeoutExt);
    w_push       = 1'b0;
    w_pushData   = w_word;
    w_pushLast   = 1'b0;
    if (w_wordDone && !w_timeoutOn) begin
      w_push     = 1'b1;
      w_pushData = w_word;
      w_pushLast = 1'b0;
    end else if (r_pendValid && w_rise) begin
      w_push     = 1'b1;
      w_pushData = r_pendData;
      w_pushLast = 1'b0;
    end else if (r_pendValid && w_timeoutHit) begin
      w_push     = 1'b1;
      w_pushData = r_pendData;
      w_pushLast = 1'b1;
    end
  end

  // Receive state machine plus the single-entry output register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= WAIT_LOW;
      r_highCnt   <= '0;
      r_lowCnt    <= '0;
      r_shreg     <= '0;
      r_bitCnt    <= '0;
      r_pendData  <= '0;
      r_pendValid <= 1'b0;
      r_tdata     <= '0;
      r_tlast     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_overrun   <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;

      case (r_state)
        WAIT_LOW: begin
          if (!r_rxdS) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (r_rxdS) begin
            r_state   <= HIGH;
            r_highCnt <= COUNTER_WIDTH'(1);
          end
        end
        HIGH: begin
          if (r_rxdS) begin
            if (r_highCnt != '1) begin
              r_highCnt <= r_highCnt + COUNTER_WIDTH'(1);
            end
          end else begin
            r_shreg  <= w_word[DATA_AXIS_DATA_WIDTH-2:0];
            r_state  <= LOW;
            r_lowCnt <= COUNTER_WIDTH'(1);
            if (w_wordDone) begin
              r_bitCnt <= '0;
              if (w_timeoutOn) begin
                r_pendData  <= w_word;
                r_pendValid <= 1'b1;
              end
            end else begin
              r_bitCnt <= r_bitCnt + BitCntW'(1);
            end
          end
        end
        LOW: begin
          if (w_timeoutHit) begin
            r_state     <= IDLE;
            r_pendValid <= 1'b0;
            if (r_bitCnt != '0) begin
              r_frameErr <= 1'b1;
              r_bitCnt   <= '0;
            end
          end else if (r_rxdS) begin
            r_state     <= HIGH;
            r_highCnt   <= COUNTER_WIDTH'(1);
            r_pendValid <= 1'b0;
          end else if (r_lowCnt != '1) begin
            r_lowCnt <= r_lowCnt + COUNTER_WIDTH'(1);
          end
        end
        default: r_state <= WAIT_LOW;
      endcase

      if (w_push) begin
        if (!r_tvalid || data_m_axis_tready) begin
          r_tdata  <= w_pushData;
          r_tlast  <= w_pushLast;
          r_tvalid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_tvalid && data_m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign data_m_axis_tdata  = r_tdata;
  assign data_m_axis_tlast  = r_tlast;
  assign data_m_axis_tvalid = r_tvalid;
  assign overrun            = r_overrun;
  assign frame_err          = r_frameErr;

endmodule
